mul_seq_32: RTL



---
 rtl/mul_pkg.sv | 35 +++
 rtl/add_pg_32.sv | 41 ++++
 rtl/mul_seq_32.sv | 111 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// Includes the prefix-merge step used by the lookahead adder.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;
  localparam int MUL_LAST  = 31;

  // One Kogge-Stone level: merge each (g,p) with the one d bits below.
  function automatic logic [63:0] pg_merge(
    input logic [31:0] g,
    input logic [31:0] p,
    input int          d
  );
    logic [31:0] gn;
    logic [31:0] pn;
    for (int i = 0; i < 32; i++) begin
      if (i >= d) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end else begin
        gn[i] = g[i];
        pn[i] = p[i];
      end
    end
    return {gn, pn};
  endfunction

endpackage

// File: rtl/add_pg_32.sv
// 32-bit parallel-prefix lookahead adder.
// Exposes group propagate/generate for chaining.
module add_pg_32
  import mul_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        prop_out,
  output logic        gen_out
);

  logic [31:0] g0, p0;
  logic [31:0] g1, p1;
  logic [31:0] g2, p2;
  logic [31:0] g3, p3;
  logic [31:0] g4, p4;
  logic [31:0] g5, p5;
  logic [32:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  assign {g1, p1} = pg_merge(g0, p0, 1);
  assign {g2, p2} = pg_merge(g1, p1, 2);
  assign {g3, p3} = pg_merge(g2, p2, 4);
  assign {g4, p4} = pg_merge(g3, p3, 8);
  assign {g5, p5} = pg_merge(g4, p4, 16);

  // g5/p5[i] span bits i..0, so each carry is one AND-OR away.
  assign c = {g5 | (p5 & {32{carry_in}}),
              carry_in};

  assign sum       = p0 ^ c[31:0];
  assign carry_out = c[32];
  assign prop_out  = p5[31];
  assign gen_out   = g5[31];

endmodule

// File: rtl/mul_seq_32.sv
// Iterative unsigned 32x32->64 shift-add multiplier.
// One multiplier bit per cycle through add_pg_32.
module mul_seq_32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz
);

  mul_state_t state, state_n;

  logic is_idle, is_busy, is_done;
  logic accept, last;

  logic [MUL_WIDTH-1:0] mcand;
  logic [MUL_WIDTH-1:0] hi, lo;
  logic [MUL_WIDTH-1:0] hi_n, lo_n;
  logic [MUL_WIDTH-1:0] sum;
  logic                 carry;
  logic [MUL_CNT_W-1:0] cnt;

  logic [2*MUL_WIDTH-1:0] prod_q;
  logic                   nz_q;

  logic unused_p, unused_g;

  assign is_idle = (state == IDLE);
  assign is_busy = (state == BUSY);
  assign is_done = (state == DONE);

  assign accept = is_idle & in_valid;
  assign last   = (cnt == MUL_CNT_W'(MUL_LAST));

  add_pg_32 u_add (
    .a         (hi),
    .b         (mcand),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry),
    .prop_out  (unused_p),
    .gen_out   (unused_g)
  );

  // Carry lands in hi[31]; the dropped bit is the consumed lo[0].
  always_comb begin
    hi_n = {1'b0, hi[MUL_WIDTH-1:1]};
    lo_n = {hi[0], lo[MUL_WIDTH-1:1]};
    if (lo[0]) begin
      hi_n = {carry, sum[MUL_WIDTH-1:1]};
      lo_n = {sum[0], lo[MUL_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      is_idle: if (in_valid)  state_n = BUSY;
      is_busy: if (last)      state_n = DONE;
      is_done: if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = is_idle;
    out_valid = is_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      prod_q <= '0;
      nz_q   <= 1'b0;
    end else if (accept) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= '0;
    end else if (is_busy) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + MUL_CNT_W'(1);
      if (last) begin
        prod_q <= {hi_n, lo_n};
        nz_q   <= |hi_n;
      end
    end
  end

  assign product = prod_q;
  assign hi_nz   = nz_q;

endmodule
